// File: rtl/depuncture_if.sv
// Depuncturer handshake/data bundle.
//   en, start, rate, data_in       : serial punctured input side (driven by master)
//   data_out_a/b, erase_a/b        : depunctured pair and erasure flags (driven by slave)
//   valid_out                      : one-cycle qualifier for the pair outputs
//   busy                           : a partial puncturing group is held
//   pair_count                     : pairs emitted since reset/start, wraps at 16 bits
interface depuncture_if;
  logic        en;
  logic        start;
  logic [1:0]  rate;
  logic        data_in;
  logic        data_out_a;
  logic        data_out_b;
  logic        erase_a;
  logic        erase_b;
  logic        valid_out;
  logic        busy;
  logic [15:0] pair_count;

  modport master (
    output en, start, rate, data_in,
    input  data_out_a, data_out_b, erase_a, erase_b, valid_out, busy, pair_count
  );

  modport slave (
    input  en, start, rate, data_in,
    output data_out_a, data_out_b, erase_a, erase_b, valid_out, busy, pair_count
  );
endinterface

// File: rtl/depuncture.sv
// Serial depuncturer for rate 1/2, 2/3 and 3/4 punctured convolutional streams.
// Reassembles the transmitted A0 B0 A1 B1 ... order into (A, B) pairs, inserting
// zero-valued erasures at punctured positions.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : depuncture_if.slave -- input strobe/data/rate, pair outputs, status
module depuncture (
  input  logic         clk,
  input  logic         rst_n,
  depuncture_if.slave  bus
);

  logic [1:0]  phase_q;
  logic [1:0]  rate_q;
  logic        a_hold_q;
  logic        data_out_a_q;
  logic        data_out_b_q;
  logic        erase_a_q;
  logic        erase_b_q;
  logic        valid_out_q;
  logic [15:0] pair_count_q;

  // Group length follows the rate latched at the start of the current group;
  // the reserved code behaves as rate 1/2.
  logic [2:0] group_len;
  always_comb begin
    group_len = 3'd2;
    case (rate_q)
      2'd1:    group_len = 3'd3;
      2'd2:    group_len = 3'd4;
      default: group_len = 3'd2;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= 2'd0;
      rate_q       <= 2'd0;
      a_hold_q     <= 1'b0;
      data_out_a_q <= 1'b0;
      data_out_b_q <= 1'b0;
      erase_a_q    <= 1'b0;
      erase_b_q    <= 1'b0;
      valid_out_q  <= 1'b0;
      pair_count_q <= 16'd0;
    end else begin
      valid_out_q <= 1'b0;
      if (bus.start && !bus.en) begin
        // Restart without a sample: drop any partial group.
        phase_q      <= 2'd0;
        pair_count_q <= 16'd0;
      end else if (bus.en) begin
        if (bus.start || phase_q == 2'd0) begin
          // First bit of a group; start discards a partial group silently.
          rate_q   <= bus.rate;
          a_hold_q <= bus.data_in;
          phase_q  <= 2'd1;
          if (bus.start) begin
            pair_count_q <= 16'd0;
          end
        end else begin
          valid_out_q  <= 1'b1;
          pair_count_q <= pair_count_q + 16'd1;
          case (phase_q)
            2'd1: begin
              data_out_a_q <= a_hold_q;
              data_out_b_q <= bus.data_in;
              erase_a_q    <= 1'b0;
              erase_b_q    <= 1'b0;
              phase_q      <= (group_len == 3'd2) ? 2'd0 : 2'd2;
            end
            2'd2: begin
              data_out_a_q <= bus.data_in;
              data_out_b_q <= 1'b0;
              erase_a_q    <= 1'b0;
              erase_b_q    <= 1'b1;
              phase_q      <= (group_len == 3'd3) ? 2'd0 : 2'd3;
            end
            default: begin
              data_out_a_q <= 1'b0;
              data_out_b_q <= bus.data_in;
              erase_a_q    <= 1'b1;
              erase_b_q    <= 1'b0;
              phase_q      <= 2'd0;
            end
          endcase
        end
      end
    end
  end

  assign bus.data_out_a = data_out_a_q;
  assign bus.data_out_b = data_out_b_q;
  assign bus.erase_a    = erase_a_q;
  assign bus.erase_b    = erase_b_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.busy       = (phase_q != 2'd0);
  assign bus.pair_count = pair_count_q;

endmodule

// File: tb/tb_depuncture.sv
// Directed scoreboard bench for the depuncturer.
module tb_depuncture;

  logic clk;
  logic rst_n;

  depuncture_if bus ();

  depuncture dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic a;
    logic b;
    logic ea;
    logic eb;
  } pair_t;

  pair_t sb[$];
  int    total;
  int    bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, push any expected pair, then check
  // outputs #1 after the next rising edge.
  task automatic step(input string tag, input bit e, input bit s, input logic [1:0] r,
                      input bit d, input bit emit, input bit xa, input bit xb,
                      input bit xea, input bit xeb, input int exp_cnt, input bit exp_busy);
    pair_t got;
    pair_t exp;
    @(negedge clk);
    bus.en      = e;
    bus.start   = s;
    bus.rate    = r;
    bus.data_in = d;
    if (emit) sb.push_back(pair_t'{xa, xb, xea, xeb});
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(bus.valid_out), 32'(emit));
    if (bus.valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_pair"}, 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        got = pair_t'{bus.data_out_a, bus.data_out_b, bus.erase_a, bus.erase_b};
        chk({tag, "_pair"}, 32'(got), 32'(exp));
      end
    end
    chk({tag, "_count"}, 32'(bus.pair_count), 32'(exp_cnt));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    bus.en      = 1'b0;
    bus.start   = 1'b0;
    bus.rate    = 2'd0;
    bus.data_in = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_data", 32'({bus.data_out_a, bus.data_out_b, bus.erase_a, bus.erase_b}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_count", 32'(bus.pair_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rate 1/2: 1,0,1,1
    step("r12_b0", 1, 1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 1);
    step("r12_b1", 1, 0, 2'd0, 0, 1, 1, 0, 0, 0, 1, 0);
    step("r12_b2", 1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 1);
    step("r12_b3", 1, 0, 2'd0, 1, 1, 1, 1, 0, 0, 2, 0);

    // Rate 2/3: 1,1,0
    step("r23_b0", 1, 1, 2'd1, 1, 0, 0, 0, 0, 0, 0, 1);
    step("r23_b1", 1, 0, 2'd1, 1, 1, 1, 1, 0, 0, 1, 1);
    step("r23_b2", 1, 0, 2'd1, 0, 1, 0, 0, 0, 1, 2, 0);

    // Rate 3/4: 1,0,1,1
    step("r34_b0", 1, 1, 2'd2, 1, 0, 0, 0, 0, 0, 0, 1);
    step("r34_b1", 1, 0, 2'd2, 0, 1, 1, 0, 0, 0, 1, 1);
    step("r34_b2", 1, 0, 2'd2, 1, 1, 1, 0, 0, 1, 2, 1);
    step("r34_b3", 1, 0, 2'd2, 1, 1, 0, 1, 1, 0, 3, 0);

    // Rate 3/4 with a 3-cycle en gap between bits 2 and 3
    step("gap_b0", 1, 1, 2'd2, 1, 0, 0, 0, 0, 0, 0, 1);
    step("gap_b1", 1, 0, 2'd2, 0, 1, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step("gap_idle", 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("gap_hold", 32'({bus.data_out_a, bus.data_out_b}), 32'b10);
    end
    step("gap_b2", 1, 0, 2'd2, 1, 1, 1, 0, 0, 1, 2, 1);
    step("gap_b3", 1, 0, 2'd2, 1, 1, 0, 1, 1, 0, 3, 0);

    // Rate change mid-group is ignored until the next group
    step("chg_b0", 1, 1, 2'd1, 1, 0, 0, 0, 0, 0, 0, 1);
    step("chg_b1", 1, 0, 2'd2, 0, 1, 1, 0, 0, 0, 1, 1);
    step("chg_b2", 1, 0, 2'd2, 1, 1, 1, 0, 0, 1, 2, 0);
    step("chg_n0", 1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 2, 1);
    step("chg_n1", 1, 0, 2'd0, 1, 1, 0, 1, 0, 0, 3, 1);
    step("chg_n2", 1, 0, 2'd0, 1, 1, 1, 0, 0, 1, 4, 1);
    step("chg_n3", 1, 0, 2'd0, 1, 1, 0, 1, 1, 0, 5, 0);

    // Reserved rate acts as 1/2
    step("rsv_b0", 1, 0, 2'd3, 1, 0, 0, 0, 0, 0, 5, 1);
    step("rsv_b1", 1, 0, 2'd2, 0, 1, 1, 0, 0, 0, 6, 0);

    // start with en=0 drops a partial group
    step("sto_b0", 1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 6, 1);
    step("sto_clr", 0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sto_n0", 1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 1);
    step("sto_n1", 1, 0, 2'd0, 1, 1, 1, 1, 0, 0, 1, 0);

    // start with en=1 mid-group discards the partial group
    step("sten_b0", 1, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 1);
    step("sten_re", 1, 1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 1);
    step("sten_b1", 1, 0, 2'd2, 0, 1, 1, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-group
    step("rmg_b0", 1, 1, 2'd2, 1, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    bus.en = 1'b0;
    bus.start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmg_busy", 32'(bus.busy), 32'd0);
    chk("rmg_count", 32'(bus.pair_count), 32'd0);
    chk("rmg_valid", 32'(bus.valid_out), 32'd0);
    #4;
    rst_n = 1'b1;
    step("rmg_n0", 1, 1, 2'd2, 1, 0, 0, 0, 0, 0, 0, 1);
    step("rmg_n1", 1, 0, 2'd2, 1, 1, 1, 1, 0, 0, 1, 1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/depuncture.md
DEPUNCTURE -- requirements
Module: depuncture

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-003 en  input  1  input-valid strobe; data_in is consumed only on edges where en=1.
REQ-004 start  input  1  synchronous group/frame restart; forces the current sample (if en=1) to phase 0.
REQ-005 rate  input  2  0=1/2, 1=2/3, 2=3/4, 3=reserved (treated as 1/2).
REQ-006 data_in  input  1  serial punctured coded bit, order A0 B0 A1 B1... as the encoder transmits.
REQ-007 data_out_a  output  1  depunctured A bit of emitted pair (0 when erased).
REQ-008 data_out_b  output  1  depunctured B bit of emitted pair (0 when erased).
REQ-009 erase_a, erase_b  output  1 each  1 = corresponding bit was punctured (dummy value).
REQ-010 valid_out  output  1  one-cycle pulse qualifying the pair/erase outputs.
REQ-011 busy  output  1  1 while phase != 0 (partial puncturing group held).
REQ-012 pair_count  output  16  number of pairs emitted since reset/start, wraps 0xFFFF->0x0000.

Function
REQ-013 All outputs registered; an emitted pair appears on the edge that samples its completing bit (visible the following cycle, latency 1).
REQ-014 Internal phase counter p; group length L = 2 (1/2), 3 (2/3), 4 (3/4); p wraps from L-1 to 0.
REQ-015 rate is latched into rate_q only when a bit is sampled at p=0; rate changes at p!=0 are ignored until the next group.
REQ-016 p=0 (all rates): store data_in as A_hold; no output; valid_out=0.
REQ-017 p=1 (all rates): emit (A_hold, data_in), erase_a=0, erase_b=0.
REQ-018 p=2 (2/3, 3/4): emit (data_in, 0), erase_a=0, erase_b=1.
REQ-019 p=3 (3/4 only): emit (0, data_in), erase_a=1, erase_b=0.
REQ-020 Each emission increments pair_count by 1 and pulses valid_out for exactly one cycle.
REQ-021 en=0: no sampling, p/A_hold/rate_q/pair_count held, valid_out=0; data outputs hold last values.
REQ-022 start=1 with en=1: pair_count cleared, bit treated as p=0 (rate latched, A_hold loaded); any partial group discarded without emission.
REQ-023 start=1 with en=0: p cleared to 0, pair_count cleared, no sample, valid_out=0.
REQ-024 Erased bit positions always drive 0 on the data output.

Reset
REQ-025 On reset=0: p=0, rate_q=0, A_hold=0, data_out_a=0, data_out_b=0, erase_a=0, erase_b=0, valid_out=0, busy=0, pair_count=0.
REQ-026 Reset asserted mid-group aborts it with no emission; first sampled bit after release is p=0.

Verification
REQ-027 rate=0, en=1, data_in 1,0,1,1 -> pairs (1,0,e=00), (1,1,e=00); valid_out after 2nd and 4th bits only; pair_count=2.
REQ-028 rate=1, data_in 1,1,0 -> (1,1,e=00) then (0,0,erase_b=1); pair_count=2; busy=0 after 3rd bit.
REQ-029 rate=2, data_in 1,0,1,1 -> (1,0,e=00), (1,0,erase_b=1), (0,1,erase_a=1); pair_count=3.
REQ-030 rate=2, en low 3 cycles between bits 2 and 3 -> no valid_out during gap, output sequence identical to REQ-029.
REQ-031 rate=1 latched, rate switched to 2 at p=1 -> group completes as 2/3 (3 bits, 2 pairs); next group uses 3/4.
REQ-032 reset pulsed low after bit 1 of a 3/4 group, then start with bits 1,1 -> no stale emission, first pair (1,1,e=00), pair_count=1.
